// File: rtl/bnn_seq_pkg.sv
// Shared types and per-layer constants for the BNN layer sequencer.
// LAYER_OC holds the output-channel count of each layer (0 = skip layer);
// LAYER_BASE holds the first weight-memory address of each layer.
package bnn_seq_pkg;

   localparam int NUM_LAYERS_DEF = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      WAIT_WT = 3'd2,
      RUN     = 3'd3,
      STORE   = 3'd4,
      NEXT    = 3'd5,
      DONE    = 3'd6
   } state_t;

   // Packed so that element [i] is layer i.
   localparam logic [NUM_LAYERS_DEF-1:0][7:0] LAYER_OC   = {8'd3, 8'd2};
   localparam logic [NUM_LAYERS_DEF-1:0][7:0] LAYER_BASE = {8'd16, 8'd0};

   // Channel count of a layer; out-of-table layers read as empty.
   function automatic logic [7:0] layer_oc(input int idx);
      if (idx >= 0 && idx < NUM_LAYERS_DEF) begin
         return LAYER_OC[idx];
      end else begin
         return 8'd0;
      end
   endfunction

   // Weight base address of a layer; out-of-table layers read as 0.
   function automatic logic [7:0] layer_base(input int idx);
      if (idx >= 0 && idx < NUM_LAYERS_DEF) begin
         return LAYER_BASE[idx];
      end else begin
         return 8'd0;
      end
   endfunction

endpackage

// File: rtl/bnn_seq_idx_ctr.sv
// Nested output-channel / layer index counter for the BNN sequencer.
// Exposes the current indices, last-flags and the combinational next indices
// so the FSM can register the weight address for the upcoming FETCH.
module bnn_seq_idx_ctr #(
   parameter int NUM_LAYERS = 2,
   parameter int MAX_OC     = 8,
   localparam int LW = $clog2(NUM_LAYERS),
   localparam int OW = $clog2(MAX_OC),
   localparam int CW = $clog2(MAX_OC + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          adv,
   input  logic [CW-1:0] oc_cnt,
   output logic [LW-1:0] layer,
   output logic [OW-1:0] oc,
   output logic          oc_last,
   output logic          layer_last,
   output logic [LW-1:0] nxt_layer,
   output logic [OW-1:0] nxt_oc
);

   // Last-flags and next index: an empty layer (oc_cnt == 0) counts as finished.
   always_comb begin
      oc_last    = (oc_cnt == CW'(0)) || (CW'(oc) == (oc_cnt - CW'(1)));
      layer_last = (layer == LW'(NUM_LAYERS - 1));
      nxt_layer  = layer;
      nxt_oc     = oc;
      if (clr) begin
         nxt_layer = LW'(0);
         nxt_oc    = OW'(0);
      end else if (adv) begin
         if (!oc_last) begin
            nxt_oc = oc + OW'(1);
         end else if (!layer_last) begin
            nxt_layer = layer + LW'(1);
            nxt_oc    = OW'(0);
         end else begin
            nxt_layer = layer;
            nxt_oc    = oc;
         end
      end else begin
         nxt_layer = layer;
         nxt_oc    = oc;
      end
   end

   // Index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         layer <= LW'(0);
         oc    <= OW'(0);
      end else begin
         layer <= nxt_layer;
         oc    <= nxt_oc;
      end
   end

endmodule

// File: rtl/bnn_layer_seq.sv
// BNN conv-layer sequencer: fetches one weight word per output channel,
// kicks the conv engine, and stores each result tagged with layer/channel.
// Optional macro BNN_SEQ_PERF_EN adds a perf_cycles busy-cycle counter.
module bnn_layer_seq
   import bnn_seq_pkg::*;
#(
   parameter int NUM_LAYERS = NUM_LAYERS_DEF,
   parameter int MAX_OC     = 8,
   parameter int WT_W       = 72,
   parameter int ADDR_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   output logic                          busy,
   output logic                          done,
   output logic                          wt_rd_en,
   output logic [ADDR_W-1:0]             wt_rd_addr,
   input  logic                          wt_rd_valid,
   input  logic [WT_W-1:0]               wt_rd_data,
   output logic [WT_W-1:0]               eng_weight,
   output logic                          eng_start,
   input  logic                          eng_done,
   output logic                          res_we,
   output logic [$clog2(NUM_LAYERS)-1:0] res_layer,
   output logic [$clog2(MAX_OC)-1:0]     res_oc
`ifdef BNN_SEQ_PERF_EN
   ,
   output logic [31:0]                   perf_cycles
`endif
);

   localparam int LW = $clog2(NUM_LAYERS);
   localparam int OW = $clog2(MAX_OC);
   localparam int CW = $clog2(MAX_OC + 1);

   state_t          state;
   logic [LW-1:0]   layer;
   logic [LW-1:0]   nxt_layer;
   logic [OW-1:0]   oc;
   logic [OW-1:0]   nxt_oc;
   logic            oc_last;
   logic            layer_last;
   logic            ctr_clr;
   logic            ctr_adv;
   logic [CW-1:0]   cur_cnt;
   logic            tgt_empty;
   logic [ADDR_W-1:0] tgt_addr;

   // Counter control and lookup of the channel that the next FETCH targets.
   always_comb begin
      ctr_clr   = (state == IDLE) && start;
      ctr_adv   = (state == NEXT) && !abort;
      cur_cnt   = CW'(layer_oc(int'(layer)));
      tgt_empty = (layer_oc(int'(nxt_layer)) == 8'd0);
      tgt_addr  = ADDR_W'(layer_base(int'(nxt_layer))) + ADDR_W'(nxt_oc);
   end

   bnn_seq_idx_ctr #(
      .NUM_LAYERS (NUM_LAYERS),
      .MAX_OC     (MAX_OC)
   ) u_idx_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (ctr_clr),
      .adv        (ctr_adv),
      .oc_cnt     (cur_cnt),
      .layer      (layer),
      .oc         (oc),
      .oc_last    (oc_last),
      .layer_last (layer_last),
      .nxt_layer  (nxt_layer),
      .nxt_oc     (nxt_oc)
   );

   // Sequencer FSM; all strobes are registered so each is high exactly in its state.
   // An empty target layer is routed straight to NEXT so no read is issued for it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         wt_rd_en   <= 1'b0;
         wt_rd_addr <= ADDR_W'(0);
         eng_weight <= WT_W'(0);
         eng_start  <= 1'b0;
         res_we     <= 1'b0;
         res_layer  <= LW'(0);
         res_oc     <= OW'(0);
      end else begin
         wt_rd_en  <= 1'b0;
         eng_start <= 1'b0;
         res_we    <= 1'b0;
         done      <= 1'b0;
         if (abort && (state != IDLE)) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     busy <= 1'b1;
                     if (tgt_empty) begin
                        state <= NEXT;
                     end else begin
                        state      <= FETCH;
                        wt_rd_en   <= 1'b1;
                        wt_rd_addr <= tgt_addr;
                     end
                  end
               end
               FETCH: state <= WAIT_WT;
               WAIT_WT: begin
                  if (wt_rd_valid) begin
                     eng_weight <= wt_rd_data;
                     eng_start  <= 1'b1;
                     state      <= RUN;
                  end
               end
               RUN: begin
                  if (eng_done) begin
                     res_we    <= 1'b1;
                     res_layer <= layer;
                     res_oc    <= oc;
                     state     <= STORE;
                  end
               end
               STORE: state <= NEXT;
               NEXT: begin
                  if (oc_last && layer_last) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else if (tgt_empty) begin
                     state <= NEXT;
                  end else begin
                     state      <= FETCH;
                     wt_rd_en   <= 1'b1;
                     wt_rd_addr <= tgt_addr;
                  end
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

`ifdef BNN_SEQ_PERF_EN
   // Busy-cycle counter: cleared on an accepted start, held while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= 32'd0;
      end else if ((state == IDLE) && start) begin
         perf_cycles <= 32'd0;
      end else if (state != IDLE) begin
         perf_cycles <= perf_cycles + 32'd1;
      end else begin
         perf_cycles <= perf_cycles;
      end
   end
`endif

endmodule
